// File: rtl/trd_cmd_q_pkg.sv
// rtl/trd_cmd_q_pkg.sv - shared types and constants for the thread command queue
// Opcode enum, queue entry layout and default timing constants.
package trd_cmd_q_pkg;

  typedef enum logic [2:0] {
    TRD_NOP  = 3'd0,
    TRD_INIT = 3'd1,
    TRD_KILL = 3'd2,
    TRD_SLP  = 3'd3,
    TRD_WAKE = 3'd4
  } trd_cmd_e;

  localparam int          TRD_Q_DEPTH = 4;
  localparam int          INIT_TMO    = 16;
  localparam logic [31:0] START_PC    = 32'h0000_1000;

  typedef struct packed {
    trd_cmd_e    op;
    logic [2:0]  act;
    logic [2:0]  obj;
    logic [31:0] pc;
  } trd_entry_t;

  // KILL/SLP/WAKE target an existing thread and must be checked against valid_trd
  function automatic logic needs_valid_obj(input trd_cmd_e op);
    return (op == TRD_KILL) || (op == TRD_SLP) || (op == TRD_WAKE);
  endfunction

endpackage

// File: rtl/trd_cmd_q_if.sv
// rtl/trd_cmd_q_if.sv - command and thread_ctrl signal bundle for trd_cmd_q
// master drives commands and pipeline status; slave is the queue.
interface trd_cmd_q_if;
  import trd_cmd_q_pkg::*;

  logic        cmd_vld;
  trd_cmd_e    cmd_op;
  logic [2:0]  cmd_act;
  logic [2:0]  cmd_obj;
  logic [31:0] cmd_pc;
  logic        cmd_rdy;

  logic        stall;
  logic        flush;
  logic        trd_full;
  logic [7:0]  valid_trd;

  logic        init_trd;
  logic        kill;
  logic        slp;
  logic        wake;
  logic [2:0]  act_trd;
  logic [2:0]  obj_trd;
  logic [31:0] init_pc;
  logic [3:0]  q_cnt;
  logic        bad_obj;
  logic        init_tmo;

  modport master (
    output cmd_vld, cmd_op, cmd_act, cmd_obj, cmd_pc,
    output stall, flush, trd_full, valid_trd,
    input  cmd_rdy, init_trd, kill, slp, wake, act_trd, obj_trd, init_pc,
    input  q_cnt, bad_obj, init_tmo
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_act, cmd_obj, cmd_pc,
    input  stall, flush, trd_full, valid_trd,
    output cmd_rdy, init_trd, kill, slp, wake, act_trd, obj_trd, init_pc,
    output q_cnt, bad_obj, init_tmo
  );

endinterface

// File: rtl/trd_cmd_fifo.sv
// rtl/trd_cmd_fifo.sv - entry storage and pointers for the thread command queue
// Pointers wrap modulo DEPTH; occupancy is a separate counter so full and empty stay distinct.
module trd_cmd_fifo
  import trd_cmd_q_pkg::*;
#(
  parameter  int DEPTH = TRD_Q_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  trd_entry_t    wr_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output trd_entry_t    rd_data_o,
  output logic [CW-1:0] cnt_o
);

  trd_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/trd_cmd_q.sv
// rtl/trd_cmd_q.sv - thread command queue between execute and thread_ctrl
// Buffers INIT/KILL/SLP/WAKE, checks legality at the head and issues one strobe per pop.
module trd_cmd_q #(
  parameter int DEPTH    = trd_cmd_q_pkg::TRD_Q_DEPTH,
  parameter int INIT_TMO = trd_cmd_q_pkg::INIT_TMO
) (
  input logic        clk,
  input logic        rst_n,
  trd_cmd_q_if.slave bus
);
  import trd_cmd_q_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(INIT_TMO) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          bad_obj_q, bad_obj_d;
  logic          init_tmo_q, init_tmo_d;

  trd_entry_t    head, wr_entry;
  logic [CW-1:0] cnt, cnt_nx;
  logic          push, pop, busy, go, held, bad, tmo, issue;

  trd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .wr_data_i (wr_entry),
    .pop_i     (pop),
    .flush_i   (bus.flush),
    .rd_data_o (head),
    .cnt_o     (cnt)
  );

  // Ready ignores a same-cycle pop so a full queue never accepts
  assign bus.cmd_rdy = rst_n && (cnt < CW'(DEPTH)) && !bus.flush;
  assign push        = bus.cmd_vld && bus.cmd_rdy && (bus.cmd_op != TRD_NOP);
  assign wr_entry    = '{op: bus.cmd_op, act: bus.cmd_act, obj: bus.cmd_obj, pc: bus.cmd_pc};

  assign busy  = (state_q != S_IDLE);
  assign go    = busy && !bus.stall && !bus.flush;
  assign held  = busy && (head.op == TRD_INIT) && bus.trd_full;
  assign tmo   = held && (wait_q == TW'(INIT_TMO - 1));
  assign bad   = busy && needs_valid_obj(head.op) && !bus.valid_trd[head.obj];
  assign issue = go && !held && !bad;
  assign pop   = go && (!held || tmo);

  always_comb begin
    cnt_nx = cnt;
    if (bus.flush)        cnt_nx = '0;
    else if (push && !pop) cnt_nx = cnt + CW'(1);
    else if (pop && !push) cnt_nx = cnt - CW'(1);
  end

  always_comb begin
    state_d    = S_ISSUE;
    wait_d     = wait_q;
    bad_obj_d  = go && bad;
    init_tmo_d = go && tmo;
    if (cnt_nx == '0)     state_d = S_IDLE;
    else if (held && !pop) state_d = S_HOLD;
    if (bus.flush || pop)  wait_d = '0;
    else if (go && held)   wait_d = wait_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      bad_obj_q  <= 1'b0;
      init_tmo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      bad_obj_q  <= bad_obj_d;
      init_tmo_q <= init_tmo_d;
    end
  end

  assign bus.init_trd = issue && (head.op == TRD_INIT);
  assign bus.kill     = issue && (head.op == TRD_KILL);
  assign bus.slp      = issue && (head.op == TRD_SLP);
  assign bus.wake     = issue && (head.op == TRD_WAKE);

  // Fields fall back to idle values whenever the queue is empty, including reset
  assign bus.act_trd  = busy ? head.act : 3'd0;
  assign bus.obj_trd  = busy ? head.obj : 3'd0;
  assign bus.init_pc  = busy ? head.pc  : START_PC;
  assign bus.q_cnt    = 4'(cnt);
  assign bus.bad_obj  = bad_obj_q;
  assign bus.init_tmo = init_tmo_q;

endmodule

// File: doc/trd_cmd_q.md
TRD_CMD_Q -- requirements
Module: trd_cmd_q

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries (power of two, 2..8).
REQ-002 Parameter INIT_TMO, default 16, SHALL set the cycles a blocked INIT head waits before it is dropped.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; one clock only.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port cmd_vld, input, 1 bit, SHALL mark a valid thread command from execute.
REQ-006 Port cmd_op, input, 3 bits (trd_cmd_e), SHALL carry the opcode: NOP, INIT, KILL, SLP or WAKE.
REQ-007 Ports cmd_act, cmd_obj, input, 3 bits each, SHALL carry the acting thread and the objective thread.
REQ-008 Port cmd_pc, input, 32 bits, SHALL carry the initial PC for INIT.
REQ-009 Port cmd_rdy, output, 1 bit, SHALL indicate the queue can accept a command.
REQ-010 Ports stall, flush, trd_full, input, 1 bit each, and valid_trd, input, 8 bits, SHALL come from thread_ctrl and the pipeline.
REQ-011 Ports init_trd, kill, slp, wake, output, 1 bit each, SHALL be the one-hot command strobes to thread_ctrl.
REQ-012 Ports act_trd, obj_trd, output, 3 bits each, and init_pc, output, 32 bits, SHALL be the command fields to thread_ctrl.
REQ-013 Ports q_cnt, output, 4 bits, and bad_obj, init_tmo, output, 1 bit each, SHALL report occupancy and drop events.

Function
REQ-014 The queue SHALL accept a command when cmd_vld && cmd_rdy && cmd_op!=NOP; a NOP SHALL never be stored.
REQ-015 cmd_rdy SHALL equal (q_cnt<DEPTH) && !flush, and SHALL NOT depend on a same-cycle pop.
REQ-016 An entry accepted at edge N SHALL be presentable at the head no earlier than the cycle after edge N; there is no bypass.
REQ-017 The head SHALL issue when the queue is non-empty, stall==0 and the head is legal; exactly one strobe is high, the fields come from the head, and the entry pops at the next edge.
REQ-018 A head KILL, SLP or WAKE with valid_trd[obj]==0 SHALL NOT drive a strobe; it pops and pulses bad_obj for 1 cycle.
REQ-019 A head INIT while trd_full==1 SHALL be held; a wait counter increments each unstalled held cycle.
REQ-020 When the wait counter reaches INIT_TMO-1, the INIT SHALL pop unissued and pulse init_tmo for 1 cycle.
REQ-021 The wait counter SHALL clear on any pop and on flush.
REQ-022 The FSM SHALL have states IDLE (empty), ISSUE (head eligible) and HOLD (INIT blocked by trd_full).
REQ-023 FSM transitions: IDLE->ISSUE on the first accept; ISSUE->HOLD when the head is INIT && trd_full; HOLD->ISSUE when trd_full falls or on timeout; any state->IDLE when the queue becomes empty.
REQ-024 While stall==1, all strobes SHALL be 0, nothing SHALL pop, and the wait counter SHALL freeze; enqueue continues.
REQ-025 A simultaneous push and pop SHALL keep q_cnt unchanged.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; q_cnt SHALL be held separately, 0..DEPTH.
REQ-027 flush SHALL empty the queue at the next edge, suppress strobes in the flush cycle and block accepts in that cycle.
REQ-028 All strobes SHALL be 0 when the queue is empty or in HOLD.

Reset
REQ-029 On rst_n low, pointers, q_cnt, the wait counter, bad_obj and init_tmo SHALL be 0 and the FSM SHALL be IDLE, asynchronously.
REQ-030 While in reset, strobes SHALL be 0, act_trd and obj_trd SHALL be 0, init_pc SHALL be START_PC and cmd_rdy SHALL be 0.
REQ-031 A reset asserted mid-HOLD SHALL discard all entries with no strobe issued.

Structure
REQ-032 The enum trd_cmd_e and the constants TRD_Q_DEPTH, INIT_TMO and START_PC SHALL live in the shared header package.
REQ-033 Entry storage and pointers SHALL be one sub-module, trd_cmd_fifo; the FSM, legality checks and counters stay in trd_cmd_q.

Verification
REQ-034 Reset then push INIT(act0, pc 0x100) and KILL(obj1, valid_trd=0x03) -> init_trd one cycle after the push, then kill with obj_trd=1 on the next cycle.
REQ-035 Push 4 commands with stall=1 -> q_cnt=4, cmd_rdy=0, no strobes; release stall -> 4 strobes on consecutive cycles, then q_cnt=0.
REQ-036 Push SLP(obj5) with valid_trd=0x01 -> no slp, bad_obj pulses once, q_cnt returns to 0.
REQ-037 Push INIT with trd_full=1 held -> HOLD, init_tmo pulses after 16 cycles, no init_trd; repeat dropping trd_full at cycle 5 -> init_trd at cycle 5.
REQ-038 Push with the queue full while popping -> push rejected; flush with 3 entries -> q_cnt=0 next cycle, no strobes.
REQ-039 Assert rst_n low in HOLD with 2 entries -> all outputs at reset values immediately; no strobe after release.
